// File: rtl/siteswap_checker_if.sv
// Throw-entry and result bundle for siteswap_checker; widths follow MAX_LEN/MAX_THROW.
interface siteswap_checker_if #(
    parameter int unsigned MAX_LEN   = 16,
    parameter int unsigned MAX_THROW = 15
);
    localparam int unsigned TW = $clog2(MAX_THROW + 1);
    localparam int unsigned LW = $clog2(MAX_LEN + 1);

    logic [TW-1:0] throw_in;
    logic          throw_valid_in;
    logic          throw_last_in;
    logic          throw_ready_out;
    logic          result_valid_out;
    logic          pattern_valid_out;
    logic [1:0]    error_out;
    logic [TW-1:0] ball_count_out;
    logic [LW-1:0] length_out;

    modport master (
        output throw_in, throw_valid_in, throw_last_in,
        input  throw_ready_out, result_valid_out, pattern_valid_out,
        input  error_out, ball_count_out, length_out
    );

    modport slave (
        input  throw_in, throw_valid_in, throw_last_in,
        output throw_ready_out, result_valid_out, pattern_valid_out,
        output error_out, ball_count_out, length_out
    );
endinterface

// File: rtl/siteswap_checker.sv
// Sequential vanilla-siteswap validator: landing-beat permutation check with early exit.
// Define SITESWAP_BALLS_EN to add the sum register and the ball-count divider.
module siteswap_checker #(
    parameter int unsigned MAX_LEN   = 16,
    parameter int unsigned MAX_THROW = 15
) (
    input  logic                clk_in,
    input  logic                rst_in,
    siteswap_checker_if.slave   bus
);
    localparam int unsigned TW = $clog2(MAX_THROW + 1);
    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned AW = $clog2(MAX_LEN + MAX_THROW);
`ifdef SITESWAP_BALLS_EN
    localparam int unsigned SW = $clog2(MAX_LEN * MAX_THROW + 1);
`endif

    localparam logic [2:0] S_LOAD   = 3'd0;
    localparam logic [2:0] S_SUM    = 3'd1;
    localparam logic [2:0] S_REDUCE = 3'd2;
    localparam logic [2:0] S_MARK   = 3'd3;
`ifdef SITESWAP_BALLS_EN
    localparam logic [2:0] S_DIVIDE = 3'd4;
`endif
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]         r_state;
    logic [TW-1:0]      r_buf [MAX_LEN];
    logic [MAX_LEN-1:0] r_occ;
    logic [LW-1:0]      r_len;
    logic [LW-1:0]      r_idx;
    logic [AW-1:0]      r_acc;
    logic [1:0]         r_err;
    logic               r_ready;
    logic               r_res_valid;
    logic               r_pat_valid;
    logic [1:0]         r_err_out;
    logic [TW-1:0]      r_bc;
    logic [LW-1:0]      r_len_out;
`ifdef SITESWAP_BALLS_EN
    logic [SW-1:0]      r_sum;
    logic [SW-1:0]      r_rem;
    logic [TW-1:0]      r_q;
    logic [SW-1:0]      w_sum_nxt;
    logic [SW-1:0]      w_rem_nxt;
    logic [TW-1:0]      w_q_nxt;
`endif

    logic [2:0]         w_state_nxt;
    logic [LW-1:0]      w_len_nxt;
    logic [LW-1:0]      w_idx_nxt;
    logic [AW-1:0]      w_acc_nxt;
    logic [1:0]         w_err_nxt;
    logic               w_store;
    logic               w_mark;
    logic               w_accept;

    assign w_accept = bus.throw_valid_in && r_ready;

    // Next-state and datapath control
    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_idx_nxt   = r_idx;
        w_acc_nxt   = r_acc;
        w_err_nxt   = r_err;
        w_store     = 1'b0;
        w_mark      = 1'b0;
`ifdef SITESWAP_BALLS_EN
        w_sum_nxt   = r_sum;
        w_rem_nxt   = r_rem;
        w_q_nxt     = r_q;
`endif
        case (r_state)
            S_LOAD: begin
                if (w_accept) begin
                    if (r_len == LW'(MAX_LEN)) begin
                        if (r_err == 2'd0) w_err_nxt = 2'd3;
                    end else begin
                        w_store   = 1'b1;
                        w_len_nxt = r_len + LW'(1);
`ifdef SITESWAP_BALLS_EN
                        w_sum_nxt = r_sum + SW'(bus.throw_in);
`endif
                        if ((r_err == 2'd0) && (32'(bus.throw_in) > MAX_THROW))
                            w_err_nxt = 2'd2;
                    end
                    w_idx_nxt = '0;
                    if (bus.throw_last_in)
                        w_state_nxt = (w_err_nxt == 2'd0) ? S_SUM : S_DONE;
                end
            end
            S_SUM: begin
                w_acc_nxt   = AW'(r_idx) + AW'(r_buf[IW'(r_idx)]);
                w_state_nxt = S_REDUCE;
            end
            S_REDUCE: begin
                if (32'(r_acc) >= 32'(r_len)) w_acc_nxt = r_acc - AW'(r_len);
                else                          w_state_nxt = S_MARK;
            end
            S_MARK: begin
                if (r_occ[IW'(r_acc)]) begin
                    w_err_nxt   = 2'd1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_mark    = 1'b1;
                    w_idx_nxt = r_idx + LW'(1);
                    if (w_idx_nxt == r_len) begin
`ifdef SITESWAP_BALLS_EN
                        w_q_nxt     = '0;
                        w_rem_nxt   = r_sum;
                        w_state_nxt = S_DIVIDE;
`else
                        w_state_nxt = S_DONE;
`endif
                    end else begin
                        w_state_nxt = S_SUM;
                    end
                end
            end
`ifdef SITESWAP_BALLS_EN
            S_DIVIDE: begin
                if (32'(r_rem) >= 32'(r_len)) begin
                    w_rem_nxt = r_rem - SW'(r_len);
                    w_q_nxt   = r_q + TW'(1);
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
`endif
            S_DONE: begin
                w_len_nxt   = '0;
                w_idx_nxt   = '0;
                w_err_nxt   = 2'd0;
`ifdef SITESWAP_BALLS_EN
                w_sum_nxt   = '0;
`endif
                w_state_nxt = S_LOAD;
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    // State, datapath and result registers; results load on the edge entering DONE
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= S_LOAD;
            r_buf       <= '{default: '0};
            r_occ       <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_acc       <= '0;
            r_err       <= 2'd0;
            r_ready     <= 1'b1;
            r_res_valid <= 1'b0;
            r_pat_valid <= 1'b0;
            r_err_out   <= 2'd0;
            r_bc        <= '0;
            r_len_out   <= '0;
`ifdef SITESWAP_BALLS_EN
            r_sum       <= '0;
            r_rem       <= '0;
            r_q         <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_len   <= w_len_nxt;
            r_idx   <= w_idx_nxt;
            r_acc   <= w_acc_nxt;
            r_err   <= w_err_nxt;
            r_ready <= (w_state_nxt == S_LOAD);
`ifdef SITESWAP_BALLS_EN
            r_sum   <= w_sum_nxt;
            r_rem   <= w_rem_nxt;
            r_q     <= w_q_nxt;
`endif
            if (r_state == S_DONE) begin
                r_buf <= '{default: '0};
                r_occ <= '0;
            end else begin
                if (w_store) r_buf[IW'(r_len)] <= bus.throw_in;
                if (w_mark)  r_occ[IW'(r_acc)] <= 1'b1;
            end
            r_res_valid <= (w_state_nxt == S_DONE);
            if (w_state_nxt == S_DONE) begin
                r_pat_valid <= (w_err_nxt == 2'd0);
                r_err_out   <= w_err_nxt;
                r_len_out   <= w_len_nxt;
`ifdef SITESWAP_BALLS_EN
                r_bc        <= (w_err_nxt == 2'd0) ? r_q : '0;
`else
                r_bc        <= '0;
`endif
            end
        end
    end

    assign bus.throw_ready_out   = r_ready;
    assign bus.result_valid_out  = r_res_valid;
    assign bus.pattern_valid_out = r_pat_valid;
    assign bus.error_out         = r_err_out;
    assign bus.ball_count_out    = r_bc;
    assign bus.length_out        = r_len_out;
endmodule

// File: tb/tb_siteswap_checker.sv
// Directed-vector bench for siteswap_checker across three parameterisations.
module tb_siteswap_checker;
`ifdef SITESWAP_BALLS_EN
    localparam int BALLS_ON = 1;
`else
    localparam int BALLS_ON = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] t_throw = '0;
    logic       t_valid = 1'b0;
    logic       t_last = 1'b0;
    logic [1:0] sel = 2'd0;
    int         n_vec = 0;
    int         n_err = 0;
    int         pulses = 0;

    always #5 clk = ~clk;

    siteswap_checker_if #(.MAX_LEN(16), .MAX_THROW(15)) bus0 ();
    siteswap_checker_if #(.MAX_LEN(16), .MAX_THROW(9))  bus1 ();
    siteswap_checker_if #(.MAX_LEN(4),  .MAX_THROW(15)) bus2 ();

    assign bus0.throw_in = t_throw;
    assign bus1.throw_in = t_throw;
    assign bus2.throw_in = t_throw;
    assign bus0.throw_last_in = t_last;
    assign bus1.throw_last_in = t_last;
    assign bus2.throw_last_in = t_last;
    assign bus0.throw_valid_in = t_valid && (sel == 2'd0);
    assign bus1.throw_valid_in = t_valid && (sel == 2'd1);
    assign bus2.throw_valid_in = t_valid && (sel == 2'd2);

    siteswap_checker #(.MAX_LEN(16), .MAX_THROW(15)) u_dut0 (.clk_in(clk), .rst_in(rst), .bus(bus0));
    siteswap_checker #(.MAX_LEN(16), .MAX_THROW(9))  u_dut1 (.clk_in(clk), .rst_in(rst), .bus(bus1));
    siteswap_checker #(.MAX_LEN(4),  .MAX_THROW(15)) u_dut2 (.clk_in(clk), .rst_in(rst), .bus(bus2));

    int rdy_m, rv_m, pv_m, err_m, bc_m, len_m;

    always_comb begin
        rdy_m = int'(bus0.throw_ready_out);
        rv_m  = int'(bus0.result_valid_out);
        pv_m  = int'(bus0.pattern_valid_out);
        err_m = int'(bus0.error_out);
        bc_m  = int'(bus0.ball_count_out);
        len_m = int'(bus0.length_out);
        if (sel == 2'd1) begin
            rdy_m = int'(bus1.throw_ready_out);
            rv_m  = int'(bus1.result_valid_out);
            pv_m  = int'(bus1.pattern_valid_out);
            err_m = int'(bus1.error_out);
            bc_m  = int'(bus1.ball_count_out);
            len_m = int'(bus1.length_out);
        end else if (sel == 2'd2) begin
            rdy_m = int'(bus2.throw_ready_out);
            rv_m  = int'(bus2.result_valid_out);
            pv_m  = int'(bus2.pattern_valid_out);
            err_m = int'(bus2.error_out);
            bc_m  = int'(bus2.ball_count_out);
            len_m = int'(bus2.length_out);
        end
    end

    always @(negedge clk)
        pulses = pulses + int'(bus0.result_valid_out) + int'(bus1.result_valid_out)
                        + int'(bus2.result_valid_out);

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one throw just after a rising edge; it is accepted on the next edge.
    task automatic put(input int t, input bit last);
        t_throw = 4'(t);
        t_valid = 1'b1;
        t_last  = last;
        @(negedge clk);
        check("ready", rdy_m, 1);
        @(posedge clk); #1;
        t_valid = 1'b0;
        t_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    // Cycle 1 is the cycle after the accepting edge of the last throw.
    task automatic expect_result(input string name, input int pv, input int err,
                                 input int bc, input int len, input int lat);
        int c;
        c = 1;
        while (rv_m == 0 && c < 400) begin
            @(posedge clk); #1;
            c++;
        end
        if (rv_m == 0) c = 0;
        check({name, ".latency"}, c, lat);
        check({name, ".valid"}, pv_m, pv);
        check({name, ".error"}, err_m, err);
        check({name, ".balls"}, bc_m, bc);
        check({name, ".length"}, len_m, len);
        @(posedge clk); #1;
        check({name, ".pulse_drop"}, rv_m, 0);
        check({name, ".hold_len"}, len_m, len);
    endtask

    initial begin
        int p0;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst.ready", rdy_m, 1);
        check("rst.rvalid", rv_m, 0);
        check("rst.pvalid", pv_m, 0);
        check("rst.error", err_m, 0);
        check("rst.balls", bc_m, 0);
        check("rst.length", len_m, 0);
        @(posedge clk); #1;

        put(5, 0); put(3, 0); put(1, 1);
        expect_result("p531", 1, 0, 3 * BALLS_ON, 3, 13 + 4 * BALLS_ON);

        put(5, 0); put(4, 0); put(3, 1);
        expect_result("p543", 0, 1, 0, 3, 9);

        idle(3);
        put(3, 1);
        expect_result("p3", 1, 0, 3 * BALLS_ON, 1, 7 + 4 * BALLS_ON);

        put(0, 0); idle(2); put(0, 1);
        expect_result("p00", 1, 0, 0, 2, 7 + BALLS_ON);

        sel = 2'd1;
        put(4, 0); put(12, 0); put(2, 1);
        expect_result("thr9", 0, 2, 0, 3, 1);

        sel = 2'd2;
        p0 = pulses;
        for (int k = 0; k < 6; k++) put(3, 0);
        put(3, 1);
        expect_result("len4", 0, 3, 0, 4, 1);
        idle(20);
        check("len4.pulses", pulses - p0, 1);

        sel = 2'd0;
        put(4, 0); put(4, 0); put(4, 1);
        idle(1);
        p0 = pulses;
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(40);
        check("abort.pulses", pulses - p0, 0);
        check("abort.pvalid", pv_m, 0);
        check("abort.error", err_m, 0);
        check("abort.balls", bc_m, 0);
        check("abort.length", len_m, 0);
        check("abort.ready", rdy_m, 1);

        put(4, 0); put(4, 0); put(1, 1);
        expect_result("p441", 1, 0, 3 * BALLS_ON, 3, 13 + 4 * BALLS_ON);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
